// File: rtl/knock_retard_if.sv
// Knock retard control bus: knock sensor and tick inputs, retard and diagnostics outputs.
interface knock_retard_if #(
  parameter int unsigned RW    = 6,
  parameter int unsigned CNT_W = 16
);
  logic             knock_detected;
  logic             cycle_tick;
  logic             clear_count;
  logic [RW-1:0]    retard_deg;
  logic             knock_event;
  logic [CNT_W-1:0] knock_count;
  logic             retard_active;
  logic             at_max;

  modport master (
    output knock_detected, cycle_tick, clear_count,
    input  retard_deg, knock_event, knock_count, retard_active, at_max
  );

  modport slave (
    input  knock_detected, cycle_tick, clear_count,
    output retard_deg, knock_event, knock_count, retard_active, at_max
  );
endinterface

// File: rtl/knock_retard_ctrl.sv
// Confirms knocks per combustion window, steps ignition retard up on each confirmed
// knock and walks it back down after a quiet hold period.
module knock_retard_ctrl #(
  parameter int unsigned RW               = 6,
  parameter int unsigned MAX_RETARD       = 20,
  parameter int unsigned RETARD_STEP      = 2,
  parameter int unsigned RECOVER_STEP     = 1,
  parameter int unsigned MIN_KNOCK_CLKS   = 4,
  parameter int unsigned HOLD_CYCLES      = 8,
  parameter int unsigned RECOVER_INTERVAL = 4,
  parameter int unsigned CNT_W            = 16
) (
  input logic            clk,
  input logic            reset,
  knock_retard_if.slave  kr
);

  localparam int unsigned WW = 8;
  localparam int unsigned QW = 16;

  typedef enum logic [1:0] {S_NORMAL, S_HOLD, S_RECOVER} state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [QW-1:0]    quiet_q, quiet_d;
  logic [RW-1:0]    retard_q, retard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             event_q, event_d;
  logic             active_q, active_d;
  logic             at_max_q, at_max_d;

  logic [WW:0]      win_sum;
  logic             confirmed;
  logic [RW:0]      retard_up;
  logic [RW-1:0]    retard_dn;
  logic [QW-1:0]    quiet_inc;
  logic [CNT_W-1:0] count_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_NORMAL;
      win_cnt_q <= '0;
      quiet_q   <= '0;
      retard_q  <= '0;
      count_q   <= '0;
      event_q   <= 1'b0;
      active_q  <= 1'b0;
      at_max_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      quiet_q   <= quiet_d;
      retard_q  <= retard_d;
      count_q   <= count_d;
      event_q   <= event_d;
      active_q  <= active_d;
      at_max_q  <= at_max_d;
    end
  end

  // The sample taken on the tick clock still belongs to the closing window.
  always_comb begin
    win_sum    = {1'b0, win_cnt_q} + (WW+1)'(kr.knock_detected);
    confirmed  = kr.cycle_tick && (win_sum >= (WW+1)'(MIN_KNOCK_CLKS));
    retard_up  = {1'b0, retard_q} + (RW+1)'(RETARD_STEP);
    retard_dn  = (retard_q > RW'(RECOVER_STEP)) ? (retard_q - RW'(RECOVER_STEP)) : '0;
    quiet_inc  = quiet_q + QW'(1);
    count_base = kr.clear_count ? '0 : count_q;
  end

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    quiet_d   = quiet_q;
    retard_d  = retard_q;
    count_d   = count_base;
    event_d   = 1'b0;

    if (kr.cycle_tick) begin
      win_cnt_d = '0;
    end else if (kr.knock_detected && (win_cnt_q != '1)) begin
      win_cnt_d = win_cnt_q + WW'(1);
    end

    if (confirmed) begin
      retard_d = (retard_up > (RW+1)'(MAX_RETARD)) ? RW'(MAX_RETARD) : retard_up[RW-1:0];
      state_d  = S_HOLD;
      quiet_d  = '0;
      event_d  = 1'b1;
      if (count_base != '1) count_d = count_base + CNT_W'(1);
    end else if (kr.cycle_tick) begin
      case (state_q)
        S_HOLD: begin
          if (quiet_inc == QW'(HOLD_CYCLES)) begin
            state_d = S_RECOVER;
            quiet_d = '0;
          end else begin
            quiet_d = quiet_inc;
          end
        end
        S_RECOVER: begin
          if (quiet_inc == QW'(RECOVER_INTERVAL)) begin
            retard_d = retard_dn;
            quiet_d  = '0;
            if (retard_dn == '0) state_d = S_NORMAL;
          end else begin
            quiet_d = quiet_inc;
          end
        end
        default: ;
      endcase
    end

    active_d = (state_d != S_NORMAL);
    at_max_d = (retard_d == RW'(MAX_RETARD));
  end

  assign kr.retard_deg    = retard_q;
  assign kr.knock_event   = event_q;
  assign kr.knock_count   = count_q;
  assign kr.retard_active = active_q;
  assign kr.at_max        = at_max_q;

endmodule

// File: tb/tb_knock_retard_ctrl.sv
// Directed bench for knock_retard_ctrl; expected values are hand-derived per scenario.
module tb_knock_retard_ctrl;

  localparam int unsigned RW    = 6;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SW    = 1 + RW + 1 + 1 + CNT_W;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  knock_retard_if #(.RW(RW), .CNT_W(CNT_W)) kif ();

  knock_retard_ctrl #(
    .RW(RW), .MAX_RETARD(20), .RETARD_STEP(2), .RECOVER_STEP(1),
    .MIN_KNOCK_CLKS(4), .HOLD_CYCLES(8), .RECOVER_INTERVAL(4), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kr    (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {knock_event, retard_deg, retard_active, at_max, knock_count}
  function automatic logic [SW-1:0] snap();
    return {kif.knock_event, kif.retard_deg, kif.retard_active, kif.at_max, kif.knock_count};
  endfunction

  function automatic logic [SW-1:0] expv(input logic ev, input int r, input logic act,
                                         input logic mx, input int cnt);
    return {ev, RW'(r), act, mx, CNT_W'(cnt)};
  endfunction

  // n knock clocks, then a tick clock carrying tick_kd/clr; returns at the following negedge
  task automatic window(input int n, input logic tick_kd, input logic clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      kif.knock_detected = 1'b1; kif.cycle_tick = 1'b0; kif.clear_count = 1'b0;
    end
    @(negedge clk);
    kif.knock_detected = tick_kd; kif.cycle_tick = 1'b1; kif.clear_count = clr;
    @(negedge clk);
    kif.knock_detected = 1'b0; kif.cycle_tick = 1'b0; kif.clear_count = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    kif.knock_detected = 1'b0; kif.cycle_tick = 1'b0; kif.clear_count = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [SW-1:0] e;
    do_reset();
    e = expv(1'b0, 0, 1'b0, 1'b0, 0);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL reset_state: got %h want %h", snap(), e);
    end
  endtask

  task automatic test_subthreshold();
    logic [SW-1:0] e;
    window(3, 1'b0, 1'b0);
    e = expv(1'b0, 0, 1'b0, 1'b0, 0);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL three_knocks: got %h want %h", snap(), e);
    end
  endtask

  task automatic test_confirm();
    logic [SW-1:0] e;
    window(4, 1'b0, 1'b0);
    e = expv(1'b1, 2, 1'b1, 1'b0, 1);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL four_knocks: got %h want %h", snap(), e);
    end
    @(negedge clk);
    e = expv(1'b0, 2, 1'b1, 1'b0, 1);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL event_one_clk: got %h want %h", snap(), e);
    end
  endtask

  task automatic test_tick_sample();
    logic [SW-1:0] e;
    do_reset();
    window(3, 1'b1, 1'b0);
    e = expv(1'b1, 2, 1'b1, 1'b0, 1);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL knock_on_tick: got %h want %h", snap(), e);
    end
  endtask

  task automatic test_saturate();
    logic [SW-1:0] e;
    int r;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      window(4, 1'b0, 1'b0);
      r = (2 * i > 20) ? 20 : 2 * i;
      e = expv(1'b1, r, 1'b1, (r == 20), i);
      nvec++;
      if (snap() !== e) begin
        nerr++; $display("FAIL saturate_win%0d: got %h want %h", i, snap(), e);
      end
    end
  endtask

  task automatic test_recovery();
    logic [SW-1:0] e;
    int r;
    do_reset();
    window(4, 1'b0, 1'b0);
    window(4, 1'b0, 1'b0);
    for (int t = 1; t <= 24; t++) begin
      window(0, 1'b0, 1'b0);
      r = (t < 12) ? 4 : (t < 16) ? 3 : (t < 20) ? 2 : (t < 24) ? 1 : 0;
      e = expv(1'b0, r, (t < 24), 1'b0, 2);
      nvec++;
      if (snap() !== e) begin
        nerr++; $display("FAIL recover_tick%0d: got %h want %h", t, snap(), e);
      end
    end
  endtask

  task automatic test_recover_reknock();
    logic [SW-1:0] e;
    do_reset();
    window(4, 1'b0, 1'b0);
    window(4, 1'b0, 1'b0);
    for (int t = 1; t <= 12; t++) window(0, 1'b0, 1'b0);
    e = expv(1'b0, 3, 1'b1, 1'b0, 2);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL reknock_pre: got %h want %h", snap(), e);
    end
    window(4, 1'b0, 1'b0);
    e = expv(1'b1, 5, 1'b1, 1'b0, 3);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL reknock_hit: got %h want %h", snap(), e);
    end
    for (int t = 1; t <= 12; t++) begin
      window(0, 1'b0, 1'b0);
      e = expv(1'b0, (t < 12) ? 5 : 4, 1'b1, 1'b0, 3);
      nvec++;
      if (snap() !== e) begin
        nerr++; $display("FAIL reknock_quiet%0d: got %h want %h", t, snap(), e);
      end
    end
  endtask

  task automatic test_clear_count();
    logic [SW-1:0] e;
    window(4, 1'b0, 1'b1);
    e = expv(1'b1, 6, 1'b1, 1'b0, 1);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL clear_with_event: got %h want %h", snap(), e);
    end
    @(negedge clk);
    kif.clear_count = 1'b1;
    @(negedge clk);
    kif.clear_count = 1'b0;
    e = expv(1'b0, 6, 1'b1, 1'b0, 0);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL clear_alone: got %h want %h", snap(), e);
    end
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      kif.knock_detected = 1'b1;
    end
    @(negedge clk);
    kif.knock_detected = 1'b0;
    reset = 1'b0;
    #1;
    e = expv(1'b0, 0, 1'b0, 1'b0, 0);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL reset_mid: got %h want %h", snap(), e);
    end
    @(negedge clk);
    reset = 1'b1;
    window(3, 1'b0, 1'b0);
    nvec++;
    if (snap() !== e) begin
      nerr++; $display("FAIL after_reset_3knock: got %h want %h", snap(), e);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b0;
    kif.knock_detected = 1'b0;
    kif.cycle_tick     = 1'b0;
    kif.clear_count    = 1'b0;
    test_reset();
    test_subthreshold();
    test_confirm();
    test_tick_sample();
    test_saturate();
    test_recovery();
    test_recover_reknock();
    test_clear_count();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
